// File: rtl/stream_sink_checker.sv
// Stream sink checker: consumes a run of beats and compares each one against an incrementing reference.
// Latency: counters and flags update on the edge that accepts a beat. ready_in is decoded from registered state only.
// Backpressure: ready_in is throttled by an 8-bit LFSR and bp_mask. Optional stall watchdog: STREAM_SINK_CHECKER_TIMEOUT_EN.
module stream_sink_checker #(
  parameter type T     = logic [7:0],
  parameter int  CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  T                 first_val,
  input  logic [CNT_W-1:0] num_beats,
  input  logic [3:0]       bp_mask,
  input  logic             valid_in,
  output logic             ready_in,
  input  T                 data_in,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output T                 first_err_data,
  output logic             timeout
);

  localparam int W = $bits(T);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [W-1:0]     exp_q, exp_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] nb_q, nb_d;
  logic             error_q, error_d;
  T                 ferr_q, ferr_d;
  logic             busy_q, done_q;
  logic             accept;
  logic             lfsr_fb;
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
  logic [7:0]       idle_q, idle_d;
  logic             tmo_q, tmo_d;
`endif

  // Taps for x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Ready only in RUN while beats remain; a zero-beat run never opens the gate.
  assign ready_in = (state_q == RUN) && (beat_q != nb_q) && ~|(lfsr_q[3:0] & bp_mask);
  assign accept   = valid_in & ready_in;

  // Next-state and datapath update; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    exp_d   = exp_q;
    beat_d  = beat_q;
    err_d   = err_q;
    nb_d    = nb_q;
    error_d = error_q;
    ferr_d  = ferr_q;
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
    idle_d  = idle_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          exp_d   = first_val;
          beat_d  = '0;
          err_d   = '0;
          nb_d    = num_beats;
          error_d = 1'b0;
          ferr_d  = T'('0);
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
          idle_d  = '0;
          tmo_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        lfsr_d = {lfsr_q[6:0], lfsr_fb};
        if (nb_q == '0) state_d = DONE;
        if (accept) begin
          beat_d = beat_q + CNT_W'(1);
          exp_d  = exp_q + W'(1);
          if (data_in != exp_q) begin
            error_d = 1'b1;
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            if (err_q == '0) ferr_d = data_in;
          end
          if (beat_q + CNT_W'(1) == nb_q) state_d = DONE;
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
          idle_d = '0;
`endif
        end
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
        else begin
          idle_d = idle_q + 8'd1;
          // The 255th consecutive stalled RUN cycle ends the run.
          if (idle_q == 8'd254) begin
            state_d = DONE;
            tmo_d   = 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= 8'hA5;
      exp_q   <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      nb_q    <= '0;
      error_q <= 1'b0;
      ferr_q  <= T'('0);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
      idle_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      lfsr_q  <= lfsr_d;
      exp_q   <= exp_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      nb_q    <= nb_d;
      error_q <= error_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
      idle_q  <= idle_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign beat_cnt       = beat_q;
  assign err_cnt        = err_q;
  assign first_err_data = ferr_q;
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
  assign timeout        = tmo_q;
`else
  assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_stream_sink_checker.sv
// Bench for stream_sink_checker: scoreboarded runs, backpressure, wrap, zero-length, restart, reset, watchdog.
module tb_stream_sink_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  first_val;
  logic [15:0] num_beats;
  logic [3:0]  bp_mask;
  logic        valid_in;
  logic        ready_in;
  logic [7:0]  data_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] beat_cnt;
  logic [15:0] err_cnt;
  logic [7:0]  first_err_data;
  logic        timeout;

  always #5 clk = ~clk;

  stream_sink_checker dut (
    .clk(clk), .reset(reset), .start(start), .first_val(first_val),
    .num_beats(num_beats), .bp_mask(bp_mask), .valid_in(valid_in),
    .ready_in(ready_in), .data_in(data_in), .busy(busy), .done(done),
    .error(error), .beat_cnt(beat_cnt), .err_cnt(err_cnt),
    .first_err_data(first_err_data), .timeout(timeout)
  );

  typedef struct {
    int beats;
    int errs;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb_q[$];
  logic [7:0] stim[$];
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; valid_in = 1'b0; data_in = '0;
    first_val = '0; num_beats = '0; bp_mask = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_lfsr = 8'hA5;
    sb_q.delete();
  endtask

  // Runs one check, comparing ready_in every RUN cycle and counters after every accepted beat.
  task automatic run_stream(input logic [7:0] fv, input logic [15:0] n, input logic [3:0] mask,
                            input int restart_at, input string name);
    logic [7:0] m_exp, m_ferr;
    int         mb, me, cyc;
    bit         m_err, in_run, m_rdy;
    exp_t       e;
    @(negedge clk);
    first_val = fv; num_beats = n; bp_mask = mask; start = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    start = 1'b0; valid_in = 1'b1;
    data_in = (stim.size() > 0) ? stim[0] : 8'h00;
    m_exp = fv; m_ferr = '0; mb = 0; me = 0; m_err = 0; in_run = 1; cyc = 0;
    while (in_run) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks += 2;
        if (beat_cnt !== 16'(e.beats)) begin errors++; $display("FAIL %s beat_cnt: got %0d expected %0d", name, beat_cnt, e.beats); end
        if (err_cnt !== 16'(e.errs)) begin errors++; $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, e.errs); end
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy cyc %0d: got %b expected 1", name, cyc, busy); end
      m_rdy = (mb != int'(n)) && ((m_lfsr[3:0] & mask) == 4'h0);
      checks++;
      if (ready_in !== m_rdy) begin errors++; $display("FAIL %s ready_in cyc %0d: got %b expected %b", name, cyc, ready_in, m_rdy); end
      if (cyc == restart_at) begin
        start = 1'b1; first_val = 8'h33; num_beats = n + 16'd7;
      end
      if (m_rdy) begin
        if (stim[mb] !== m_exp) begin
          if (me == 0) m_ferr = stim[mb];
          m_err = 1;
          if (me < 65535) me++;
        end
        mb++; m_exp++;
        e.beats = mb; e.errs = me;
        sb_q.push_back(e);
      end
      m_lfsr = lfsr_step(m_lfsr);
      if (n == 16'd0 || (m_rdy && mb == int'(n))) in_run = 0;
      @(negedge clk);
      start = 1'b0;
      data_in = (mb < stim.size()) ? stim[mb] : 8'h00;
      cyc++;
      if (cyc > 2000) begin
        errors++; checks++;
        $display("FAIL %s run did not complete: beats %0d of %0d", name, mb, n);
        in_run = 0;
      end
    end
    valid_in = 1'b0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks += 2;
      if (beat_cnt !== 16'(e.beats)) begin errors++; $display("FAIL %s last beat_cnt: got %0d expected %0d", name, beat_cnt, e.beats); end
      if (err_cnt !== 16'(e.errs)) begin errors++; $display("FAIL %s last err_cnt: got %0d expected %0d", name, err_cnt, e.errs); end
    end
    checks += 6;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s done/busy: got %b/%b expected 1/0", name, done, busy); end
    if (ready_in !== 1'b0) begin errors++; $display("FAIL %s ready_in after run: got %b expected 0", name, ready_in); end
    if (beat_cnt !== 16'(mb)) begin errors++; $display("FAIL %s final beat_cnt: got %0d expected %0d", name, beat_cnt, mb); end
    if (error !== m_err || err_cnt !== 16'(me)) begin errors++; $display("FAIL %s error/err_cnt: got %b/%0d expected %b/%0d", name, error, err_cnt, m_err, me); end
    if (first_err_data !== m_ferr) begin errors++; $display("FAIL %s first_err_data: got %h expected %h", name, first_err_data, m_ferr); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL %s timeout: got %b expected 0", name, timeout); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || beat_cnt !== 16'(mb) || err_cnt !== 16'(me)) begin
      errors++; $display("FAIL %s hold in DONE: done %b beat_cnt %0d err_cnt %0d", name, done, beat_cnt, err_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; valid_in = 1'b1; data_in = '0;
    first_val = '0; num_beats = 16'd3; bp_mask = '0;
    #1;
    checks++;
    if ({ready_in, busy, done, error, timeout} !== 5'b0 || beat_cnt !== 16'd0 || err_cnt !== 16'd0 || first_err_data !== 8'h00) begin
      errors++; $display("FAIL reset_state: rdy %b busy %b done %b err %b tmo %b bc %0d ec %0d fe %h expected all 0",
                          ready_in, busy, done, error, timeout, beat_cnt, err_cnt, first_err_data);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    stim = '{8'hA0, 8'hA1, 8'hA2};
    run_stream(8'hA0, 16'd3, 4'h0, -1, "back_to_back");
  endtask

  task automatic test_backpressure();
    do_reset();
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'(8'h10 + i));
    run_stream(8'h10, 16'd20, 4'hF, -1, "backpressure");
  endtask

  task automatic test_wrap();
    stim = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_stream(8'hFE, 16'd4, 4'h0, -1, "wrap_clean");
    stim = '{8'hFE, 8'hFF, 8'h05, 8'h06};
    run_stream(8'hFE, 16'd4, 4'h5, -1, "wrap_errors");
  endtask

  task automatic test_zero_and_restart();
    stim.delete();
    run_stream(8'h00, 16'd0, 4'h0, -1, "zero_beats");
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(8'(8'h40 + i));
    run_stream(8'h40, 16'd6, 4'h3, 2, "restart_ignored");
  endtask

  task automatic test_reset_midrun();
    do_reset();
    @(negedge clk);
    first_val = 8'h00; num_beats = 16'd5; bp_mask = 4'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; valid_in = 1'b1; data_in = 8'h55;
    @(negedge clk);
    data_in = 8'h01;
    @(negedge clk);
    data_in = 8'h02;
    checks++;
    if (beat_cnt !== 16'd2 || error !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_pre: beat_cnt %0d error %b busy %b expected 2/1/1", beat_cnt, error, busy);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({ready_in, busy, done, error, timeout} !== 5'b0 || beat_cnt !== 16'd0 || err_cnt !== 16'd0 || first_err_data !== 8'h00) begin
      errors++; $display("FAIL midrun_async_clear: rdy %b busy %b done %b err %b bc %0d ec %0d fe %h expected all 0",
                          ready_in, busy, done, error, beat_cnt, err_cnt, first_err_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_lfsr = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || ready_in !== 1'b0 || beat_cnt !== 16'd0) begin
        errors++; $display("FAIL midrun_stays_idle %0d: busy %b done %b rdy %b bc %0d expected 0", i, busy, done, ready_in, beat_cnt);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    @(negedge clk);
    first_val = 8'h00; num_beats = 16'd5; bp_mask = 4'h0; start = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
    checks += 2;
    if (cnt != 255) begin errors++; $display("FAIL timeout_cycles: got %0d expected 255", cnt); end
    if (done !== 1'b1 || timeout !== 1'b1 || error !== 1'b0 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL timeout_done: done %b timeout %b error %b err_cnt %0d expected 1/1/0/0", done, timeout, error, err_cnt);
    end
`else
    checks += 2;
    if (cnt != 400) begin errors++; $display("FAIL no_timeout_run: RUN ended after %0d cycles expected to persist 400", cnt); end
    if (timeout !== 1'b0 || done !== 1'b0 || beat_cnt !== 16'd0) begin
      errors++; $display("FAIL no_timeout_state: timeout %b done %b beat_cnt %0d expected 0/0/0", timeout, done, beat_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_zero_and_restart();
    test_reset_midrun();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
